// File: rtl/boot_cmd_decoder.sv
// boot_cmd_decoder: decodes SPI command frames into memory writes/reads, boot control and a sticky error flag.
module boot_cmd_decoder (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  B0,
    input  logic [7:0]  B1,
    input  logic [7:0]  B2,
    input  logic [7:0]  B3,
    input  logic [7:0]  B4,
    input  logic [7:0]  B5,
    input  logic [5:0]  STROBE,
    output logic [31:0] RDATA_OUT,
    output logic [15:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic        MEM_WE,
    output logic        MEM_RE,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic        BOOT_HOLD,
    output logic        BOOT_GO,
    output logic        BUSY,
    output logic        ERR
);
    typedef enum logic [1:0] {IDLE, WR, RD} state_t;
    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_SETADDR = 8'h10;
    localparam logic [7:0] OP_WRITE   = 8'h20;
    localparam logic [7:0] OP_READ    = 8'h30;
    localparam logic [7:0] OP_BOOT    = 8'h50;
    localparam logic [7:0] OP_HALT    = 8'h51;
    localparam logic [7:0] OP_CLRERR  = 8'h60;
    localparam logic [7:0] BOOT_KEY   = 8'hA5;
    state_t      state, state_nx;
    logic [7:0]  opcode, b2_q, b3_q, b4_q;
    logic [15:0] ptr;
    logic [31:0] pend;
    logic        in_frame, pend_v;
    logic        s1, s3, s5, known, ack, rd_ack;
    logic        wr_req, rd_req, sa_req, wr_go, rd_go, sa_go;
    logic        boot_ok, boot_bad, err_set, err_clr, halt;
    assign s1       = STROBE[1] && in_frame;
    assign s3       = STROBE[3] && in_frame;
    assign s5       = STROBE[5] && in_frame;
    assign known    = opcode inside {OP_NOP, OP_SETADDR, OP_WRITE, OP_READ, OP_BOOT, OP_HALT, OP_CLRERR};
    assign BUSY     = state != IDLE;
    assign MEM_WE   = state == WR;
    assign MEM_RE   = state == RD;
    assign ack      = BUSY && MEM_ACK;
    assign rd_ack   = ack && state == RD;
    assign wr_req   = s5 && opcode == OP_WRITE;
    assign rd_req   = s1 && opcode == OP_READ;
    assign sa_req   = s3 && opcode == OP_SETADDR;
    assign wr_go    = wr_req && !BUSY;
    assign rd_go    = rd_req && !BUSY;
    assign sa_go    = sa_req && !BUSY;
    assign boot_ok  = s1 && opcode == OP_BOOT && B1 == BOOT_KEY;
    assign boot_bad = s1 && opcode == OP_BOOT && B1 != BOOT_KEY;
    assign halt     = s1 && opcode == OP_HALT;
    assign err_clr  = s1 && opcode == OP_CLRERR;
    assign err_set  = (BUSY && (wr_req || rd_req || sa_req)) || (s1 && !known) || boot_bad;
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = ack ? IDLE : wr_go ? WR : rd_go ? RD : state;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            opcode    <= OP_NOP;
            in_frame  <= 1'b0;
            b2_q      <= '0;
            b3_q      <= '0;
            b4_q      <= '0;
            ptr       <= '0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            RDATA_OUT <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            ERR       <= 1'b0;
            BOOT_GO   <= 1'b0;
            BOOT_HOLD <= 1'b1;
        end else begin
            if (STROBE[0]) begin
                opcode   <= B0;
                in_frame <= 1'b1;
            end else if (STROBE[5]) begin
                in_frame <= 1'b0;
            end
            if (STROBE[2]) b2_q <= B2;
            if (STROBE[3]) b3_q <= B3;
            if (STROBE[4]) b4_q <= B4;
            if (sa_go) ptr <= {b2_q, B3};
            else if (ack) ptr <= ptr + 16'd1;
            if (wr_go || rd_go) MEM_ADDR <= ptr;
            if (wr_go) MEM_WDATA <= {b2_q, b3_q, b4_q, B5};
            // readback must not move under a frame being shifted out; park it until the next opcode byte
            if (rd_ack && (STROBE[0] || !in_frame)) begin
                RDATA_OUT <= MEM_RDATA;
                pend_v    <= 1'b0;
            end else if (rd_ack) begin
                pend   <= MEM_RDATA;
                pend_v <= 1'b1;
            end else if (STROBE[0] && pend_v) begin
                RDATA_OUT <= pend;
                pend_v    <= 1'b0;
            end
            ERR     <= err_set || (ERR && !err_clr);
            BOOT_GO <= boot_ok;
            if (boot_ok) BOOT_HOLD <= 1'b0;
            else if (halt) BOOT_HOLD <= 1'b1;
        end
    end
endmodule
